// File: rtl/cache_bus_arbiter.sv
// cache_bus_arbiter: round-robin owner arbitration of the shared cache bus
// port among MASTER_CNT refill engines (0 = icache, 1 = dcache, 2 = optional
// uncached store buffer). One master owns the bus from address phase through
// the final data beat. Only the owner sees bridge responses.
// Optional build macro: CACHE_BUS_ARB_TIMEOUT_EN enables the stall watchdog
// that drives the sticky timeout_o flag. Without it timeout_o is tied low.

package cache_bus_pkg;
    typedef struct packed {
        logic        valid;
        logic        write;
        logic        burst;
        logic        cached;
        logic [31:0] addr;
        logic [31:0] w_data;
        logic [3:0]  data_strobe;
        logic        data_ok;
        logic        data_last;
    } cache_bus_req_t;

    typedef struct packed {
        logic        ready;
        logic [31:0] r_data;
        logic        data_ok;
        logic        data_last;
    } cache_bus_resp_t;
endpackage

module cache_bus_arbiter
    import cache_bus_pkg::*;
#(
    parameter int MASTER_CNT     = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                             clk,
    input  logic                             rst,
    input  cache_bus_req_t  [MASTER_CNT-1:0] m_req_i,
    output cache_bus_resp_t [MASTER_CNT-1:0] m_resp_o,
    output cache_bus_req_t                   s_req_o,
    input  cache_bus_resp_t                  s_resp_i,
    output logic            [MASTER_CNT-1:0] grant_o,
    output logic                             timeout_o
);

    localparam int IW = (MASTER_CNT > 2) ? 2 : 1;

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        ADDR = 3'b010,
        DATA = 3'b100
    } state_t;

    state_t                  state_q;
    logic [MASTER_CNT-1:0]   grant_q;
    logic [IW-1:0]           owner_q;
    logic [IW-1:0]           rr_ptr_q;

    logic [MASTER_CNT-1:0]   valid_vec;
    logic                    pick_found;
    logic [IW-1:0]           pick_idx;
    logic [IW:0]             cand;
    logic                    owner_valid;
    logic                    complete;

    // Per-master valid collection and owner-only response steering
    // (non-owners see all zeros, including r_data).
    for (genvar gi = 0; gi < MASTER_CNT; gi++) begin : g_master
        assign valid_vec[gi]   = m_req_i[gi].valid;
        assign m_resp_o[gi]    = grant_q[gi] ? s_resp_i : '0;
    end

    assign owner_valid = valid_vec[owner_q];
    assign complete    = s_resp_i.data_ok & s_resp_i.data_last;
    assign grant_o     = grant_q;

    // Round-robin search: first valid master starting just after rr_ptr.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 1; i <= MASTER_CNT; i++) begin
            cand = {1'b0, rr_ptr_q} + (IW+1)'(i);
            if (cand >= (IW+1)'(MASTER_CNT)) begin
                cand = cand - (IW+1)'(MASTER_CNT);
            end
            if (!pick_found && valid_vec[cand[IW-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[IW-1:0];
            end
        end
    end

    // Forward the owner's request to the bridge; address valid only in ADDR.
    always_comb begin
        s_req_o = '0;
        if (state_q != IDLE) begin
            s_req_o = m_req_i[owner_q];
            if (state_q == DATA) begin
                s_req_o.valid = 1'b0;
            end
        end
    end

    // Ownership FSM: IDLE arbitrates, ADDR waits for ready, DATA for last beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            owner_q  <= '0;
            rr_ptr_q <= IW'(MASTER_CNT - 1);
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        state_q <= ADDR;
                        grant_q <= MASTER_CNT'(1) << pick_idx;
                        owner_q <= pick_idx;
                    end
                end
                ADDR: begin
                    // Owner withdrew before the handshake: no transaction, keep rr_ptr.
                    if (!owner_valid) begin
                        state_q <= IDLE;
                        grant_q <= '0;
                    end else if (s_resp_i.ready) begin
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (complete) begin
                        state_q  <= IDLE;
                        grant_q  <= '0;
                        rr_ptr_q <= owner_q;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

`ifdef CACHE_BUS_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] wdog_cnt_q;
    logic [CW-1:0] wdog_cnt_d;
    logic          timeout_q;

    // Stall counter: any bridge progress clears it; it saturates at the limit.
    always_comb begin
        wdog_cnt_d = wdog_cnt_q;
        if (state_q == IDLE || s_resp_i.ready || s_resp_i.data_ok) begin
            wdog_cnt_d = '0;
        end else if (wdog_cnt_q != CW'(TIMEOUT_CYCLES)) begin
            wdog_cnt_d = wdog_cnt_q + CW'(1);
        end
    end

    // Counter register and sticky flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            wdog_cnt_q <= wdog_cnt_d;
            if (wdog_cnt_d == CW'(TIMEOUT_CYCLES)) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

endmodule
